overload_frame: RTL

Generates and tracks the CAN overload frame that follows an overload condition flagged by the interframe-space stage. It sits directly downstream of that stage. It consumes its `isOverload` pulse, drives the 6-bit dominant overload flag onto `canTX`, and waits out flag superposition and the 8-bit recessive delimiter. It then returns `endOverload` so the interframe-space stage restarts intermission. It enforces the limit on consecutive overload frames and reports bit, form and stuck-dominant errors.

---
 rtl/overload_frame_if.sv | 31 +++
 rtl/overload_frame.sv | 120 ++++++++++++
 2 files changed

// File: rtl/overload_frame_if.sv
// Bus between the interframe-space stage and the overload frame generator.
// The master side issues requests and observes the bus; the slave side is the generator.
interface overload_frame_if #(
    parameter int MAX_OVERLOADS = 2
);
    localparam int CNT_W = $clog2(MAX_OVERLOADS + 1);

    logic             canRX;
    logic             isOverload;
    logic             isStart;
    logic             canTX;
    logic             endOverload;
    logic             overloadActive;
    logic             bitError;
    logic             formError;
    logic             dominantError;
    logic             limitReached;
    logic [CNT_W-1:0] overloadCount;

    modport master (
        output canRX, isOverload, isStart,
        input  canTX, endOverload, overloadActive, bitError, formError,
               dominantError, limitReached, overloadCount
    );

    modport slave (
        input  canRX, isOverload, isStart,
        output canTX, endOverload, overloadActive, bitError, formError,
               dominantError, limitReached, overloadCount
    );
endinterface

// File: rtl/overload_frame.sv
// CAN overload frame generator: drives the dominant flag, rides out superposed flags,
// checks the recessive delimiter and limits back-to-back overload frames.
module overload_frame #(
    parameter int FLAG_BITS     = 6,
    parameter int DELIM_BITS    = 8,
    parameter int DOM_LIMIT     = 8,
    parameter int MAX_OVERLOADS = 2
) (
    input  logic           samplePoint,
    input  logic           resetN,
    overload_frame_if.slave bus
);
    localparam int BIT_MAX = (FLAG_BITS > DELIM_BITS) ? FLAG_BITS : DELIM_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);
    localparam int DOM_W   = $clog2(DOM_LIMIT + 1);
    localparam int CNT_W   = $clog2(MAX_OVERLOADS + 1);

    typedef enum logic [1:0] {IDLE, FLAG, WAIT, DELIM} state_t;

    state_t           state_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [DOM_W-1:0] dom_cnt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             can_tx_q, active_q;
    logic             end_q, bit_err_q, form_err_q, dom_err_q, limit_q;
    logic             accept;

    assign accept = bus.isOverload && (state_q == IDLE) && (cnt_q < CNT_W'(MAX_OVERLOADS));

    // isStart clears first so a same-edge accepted request leaves the count at one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = bus.isStart ? '0 : cnt_q;
        if (accept) cnt_d = cnt_d + CNT_W'(1);
    end

    // NOTE: state is updated with <= only, so every branch sees the pre-edge values.
    always_ff @(posedge samplePoint) begin
        if (!resetN) begin
            state_q    <= IDLE;
            can_tx_q   <= 1'b1;
            active_q   <= 1'b0;
            end_q      <= 1'b0;
            bit_err_q  <= 1'b0;
            form_err_q <= 1'b0;
            dom_err_q  <= 1'b0;
            limit_q    <= 1'b0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            dom_cnt_q  <= '0;
        end else begin
            end_q      <= 1'b0;
            bit_err_q  <= 1'b0;
            form_err_q <= 1'b0;
            dom_err_q  <= 1'b0;
            limit_q    <= 1'b0;
            cnt_q      <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= FLAG;
                        can_tx_q  <= 1'b0;
                        active_q  <= 1'b1;
                        bit_cnt_q <= '0;
                    end else if (bus.isOverload) begin
                        limit_q <= 1'b1;
                    end
                end
                FLAG: begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    if (bus.canRX) begin
                        bit_err_q <= 1'b1;
                        can_tx_q  <= 1'b1;
                        active_q  <= 1'b0;
                        state_q   <= IDLE;
                    end else if (bit_cnt_q == BIT_W'(FLAG_BITS - 1)) begin
                        can_tx_q  <= 1'b1;
                        dom_cnt_q <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // The first recessive bit seen here is already delimiter bit 1.
                    if (bus.canRX) begin
                        bit_cnt_q <= BIT_W'(1);
                        state_q   <= DELIM;
                    end else if (dom_cnt_q == DOM_W'(DOM_LIMIT - 1)) begin
                        dom_err_q <= 1'b1;
                        dom_cnt_q <= '0;
                    end else begin
                        dom_cnt_q <= dom_cnt_q + DOM_W'(1);
                    end
                end
                DELIM: begin
                    if (bus.canRX) begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(DELIM_BITS - 1)) begin
                            end_q    <= 1'b1;
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        form_err_q <= 1'b1;
                        active_q   <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.canTX          = can_tx_q;
    assign bus.overloadActive = active_q;
    assign bus.endOverload    = end_q;
    assign bus.bitError       = bit_err_q;
    assign bus.formError      = form_err_q;
    assign bus.dominantError  = dom_err_q;
    assign bus.limitReached   = limit_q;
    assign bus.overloadCount  = cnt_q;
endmodule
